// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, issues req/ready fetches to imem and buffers one instruction for decode
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redirect_valid,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_if_ack,
  input  logic        i_imem_ready,
  input  logic [15:0] i_imem_data,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  output logic        o_if_valid,
  output logic [15:0] o_if_instr,
  output logic [15:0] o_if_pc,
  output logic [15:0] o_if_pc_plus_two,
  output logic        o_halted
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SQUASH, S_HALT} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_pc, r_req_addr, r_if_instr, r_if_pc, r_if_pc_plus_two;
  logic        r_if_valid;
  logic [15:0] w_redirect_pc, w_addr;
  logic        w_can_issue, w_issue, w_cap, w_hlt, w_flush;
  assign w_redirect_pc = {i_redirect_pc[15:1], 1'b0};
  assign w_can_issue   = !r_if_valid || i_if_ack;
  assign w_issue       = (r_state == S_IDLE) && !i_redirect_valid && w_can_issue;
  assign w_cap         = i_imem_ready && (w_issue || ((r_state == S_WAIT) && !i_redirect_valid));
  assign w_hlt         = w_cap && (i_imem_data[15:12] == HLT_OPCODE);
  assign w_flush       = i_redirect_valid && (r_state != S_SQUASH);
  // state register; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  // next-state: a redirect during an outstanding fetch must still wait out imem_ready
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_issue ? (i_imem_ready ? (w_hlt ? S_HALT : S_IDLE) : S_WAIT) : S_IDLE;
      S_WAIT:   w_next = i_imem_ready ? (w_hlt ? S_HALT : S_IDLE) : (i_redirect_valid ? S_SQUASH : S_WAIT);
      S_SQUASH: w_next = i_imem_ready ? S_IDLE : S_SQUASH;
      S_HALT:   w_next = i_redirect_valid ? S_IDLE : S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end
  // outputs: request held at req_addr while a fetch is outstanding, suppressed during reset
  always_comb begin
    w_addr      = (r_state == S_IDLE) ? r_pc : r_req_addr;
    o_imem_addr = w_addr;
    o_imem_req  = rst_n && (w_issue || (r_state == S_WAIT) || (r_state == S_SQUASH));
    o_halted    = (r_state == S_HALT);
  end
  // fetch PC: redirect wins, a HLT parks the PC on itself, otherwise advance on issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_req_addr <= 16'h0000;
    end else begin
      r_pc       <= i_redirect_valid ? w_redirect_pc : w_hlt ? w_addr : w_issue ? r_pc + 16'd2 : r_pc;
      r_req_addr <= w_issue ? r_pc : r_req_addr;
    end
  end
  // single-entry buffer: flush beats refill beats ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid       <= 1'b0;
      r_if_instr       <= 16'h0000;
      r_if_pc          <= 16'h0000;
      r_if_pc_plus_two <= 16'h0002;
    end else if (w_flush) begin
      r_if_valid <= 1'b0;
    end else if (w_cap) begin
      r_if_valid       <= 1'b1;
      r_if_instr       <= i_imem_data;
      r_if_pc          <= w_addr;
      r_if_pc_plus_two <= w_addr + 16'd2;
    end else if (i_if_ack) begin
      r_if_valid <= 1'b0;
    end
  end
  assign o_if_valid       = r_if_valid;
  assign o_if_instr       = r_if_instr;
  assign o_if_pc          = r_if_pc;
  assign o_if_pc_plus_two = r_if_pc_plus_two;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer with a latency-programmable imem model
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid, if_ack, imem_ready;
  logic [15:0] redirect_pc, imem_data;
  logic        imem_req, if_valid, halted;
  logic [15:0] imem_addr, if_instr, if_pc, if_pc_plus_two;
  int          n_chk = 0, n_err = 0;
  int          lat = 1, wait_cnt = 0, bad;
  logic        hlt_en = 1'b0;
  typedef struct packed { logic [15:0] pc; logic [15:0] instr; } exp_t;
  exp_t        q[$];

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .i_if_ack(if_ack), .i_imem_ready(imem_ready), .i_imem_data(imem_data),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .o_if_valid(if_valid), .o_if_instr(if_instr), .o_if_pc(if_pc),
    .o_if_pc_plus_two(if_pc_plus_two), .o_halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return (hlt_en && a == 16'h0006) ? 16'hF123 : {4'h1, a[11:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] instr);
    q.push_back({pc, instr});
  endtask

  task automatic pe;
    @(posedge clk);
    #1;
  endtask

  task automatic ne;
    @(negedge clk);
  endtask

  // imem model: answers after lat cycles of continuous request
  always @(negedge clk) begin
    if (!rst_n || !imem_req) imem_ready = 1'b0;
    else begin
      imem_ready = (wait_cnt >= lat - 1);
      imem_data  = mem(imem_addr);
    end
  end
  always @(posedge clk) wait_cnt <= (!rst_n || !imem_req || imem_ready) ? 0 : wait_cnt + 1;

  // monitor: every instruction handed to decode must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && if_valid && if_ack) begin
      if (q.size() == 0) chk("mon_unexpected_pc", {16'h0, if_pc}, 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_pc", {16'h0, if_pc}, {16'h0, e.pc});
        chk("mon_instr", {16'h0, if_instr}, {16'h0, e.instr});
        chk("mon_pc_plus_two", {16'h0, if_pc_plus_two}, {16'h0, e.pc + 16'd2});
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: run did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; if_ack = 1'b0;
    imem_ready = 1'b0; imem_data = 16'h0;
    repeat (2) @(posedge clk);
    ne;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", {16'h0, imem_addr}, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", {16'h0, if_instr}, 32'h0);
    chk("rst_pc", {16'h0, if_pc}, 32'h0);
    chk("rst_pc2", {16'h0, if_pc_plus_two}, 32'h2);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    // 1: back-to-back fetch, one per cycle
    pe; rst_n = 1'b1; if_ack = 1'b1;
    for (int i = 0; i < 8; i++) push(16'(2 * i), mem(16'(2 * i)));
    for (int i = 0; i < 8; i++) begin
      ne;
      chk("t1_req", {31'h0, imem_req}, 32'h1);
      chk("t1_addr", {16'h0, imem_addr}, 32'(2 * i));
    end
    // 3: decode stalls, buffer held, no new request
    pe; if_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ne;
      chk("t3_req", {31'h0, imem_req}, 32'h0);
      chk("t3_valid", {31'h0, if_valid}, 32'h1);
      chk("t3_instr", {16'h0, if_instr}, 32'h100E);
      chk("t3_pc", {16'h0, if_pc}, 32'h000E);
    end
    // 2: latency 3, address stable while waiting; resumes at 0x0010
    pe; if_ack = 1'b1; lat = 3;
    push(16'h0010, 16'h1010); push(16'h0012, 16'h1012);
    for (int k = 0; k < 2; k++)
      repeat (3) begin
        ne;
        chk("t2_req", {31'h0, imem_req}, 32'h1);
        chk("t2_addr", {16'h0, imem_addr}, 32'(16 + 2 * k));
      end
    // 4: redirect while waiting, stale data dropped
    pe; ne;
    chk("t4_addr_pre", {16'h0, imem_addr}, 32'h0014);
    pe; redirect_valid = 1'b1; redirect_pc = 16'h0100;
    ne;
    chk("t4_req_wait", {31'h0, imem_req}, 32'h1);
    chk("t4_addr_wait", {16'h0, imem_addr}, 32'h0014);
    pe; redirect_valid = 1'b0;
    ne;
    chk("t4_req_squash", {31'h0, imem_req}, 32'h1);
    chk("t4_addr_squash", {16'h0, imem_addr}, 32'h0014);
    pe; lat = 1; push(16'h0100, 16'h1100);
    ne;
    chk("t4_addr_new", {16'h0, imem_addr}, 32'h0100);
    chk("t4_valid_dropped", {31'h0, if_valid}, 32'h0);
    // 5: halt at 0x0006 (redirect bit 0 ignored)
    pe; redirect_valid = 1'b1; redirect_pc = 16'h0003; hlt_en = 1'b1;
    push(16'h0002, 16'h1002); push(16'h0004, 16'h1004); push(16'h0006, 16'hF123);
    ne;
    chk("t5_req_redir", {31'h0, imem_req}, 32'h0);
    pe; redirect_valid = 1'b0;
    ne; chk("t5_addr2", {16'h0, imem_addr}, 32'h0002);
    ne; chk("t5_addr4", {16'h0, imem_addr}, 32'h0004);
    ne; chk("t5_addr6", {16'h0, imem_addr}, 32'h0006);
    pe; if_ack = 1'b0;
    ne;
    hlt_en = 1'b0;
    chk("t5_halted", {31'h0, halted}, 32'h1);
    chk("t5_pc", {16'h0, if_pc}, 32'h0006);
    chk("t5_instr", {16'h0, if_instr}, 32'hF123);
    chk("t5_valid", {31'h0, if_valid}, 32'h1);
    chk("t5_req", {31'h0, imem_req}, 32'h0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      pe; if (i == 3) if_ack = 1'b1;
      ne;
      if (imem_req) bad++;
      if (!halted) bad++;
    end
    chk("t5_halt_hold", 32'(bad), 32'h0);
    pe; redirect_valid = 1'b1; redirect_pc = 16'h0020;
    push(16'h0020, 16'h1020); push(16'h0022, 16'h1022);
    ne;
    chk("t5_redir_req", {31'h0, imem_req}, 32'h0);
    pe; redirect_valid = 1'b0;
    ne;
    chk("t5_unhalted", {31'h0, halted}, 32'h0);
    chk("t5_resume_addr", {16'h0, imem_addr}, 32'h0020);
    ne; chk("t5_next_addr", {16'h0, imem_addr}, 32'h0022);
    // 6: wrap at top of address space, then reset mid-wait
    pe; redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    push(16'hFFFE, 16'h1FFE); push(16'h0000, 16'h1000);
    ne;
    chk("t6_req_redir", {31'h0, imem_req}, 32'h0);
    pe; redirect_valid = 1'b0;
    ne; chk("t6_addr_fffe", {16'h0, imem_addr}, 32'hFFFE);
    ne; chk("t6_addr_wrap", {16'h0, imem_addr}, 32'h0000);
    pe; lat = 3;
    ne;
    chk("t6_req_wait", {31'h0, imem_req}, 32'h1);
    chk("t6_addr_wait", {16'h0, imem_addr}, 32'h0002);
    pe; rst_n = 1'b0;
    ne;
    chk("t6_rst_req", {31'h0, imem_req}, 32'h0);
    chk("t6_rst_valid", {31'h0, if_valid}, 32'h0);
    chk("t6_rst_addr", {16'h0, imem_addr}, 32'h0000);
    pe; rst_n = 1'b1; push(16'h0000, 16'h1000);
    ne;
    chk("t6_restart_req", {31'h0, imem_req}, 32'h1);
    chk("t6_restart_addr", {16'h0, imem_addr}, 32'h0000);
    ne; ne;
    pe; ne;
    pe; if_ack = 1'b0;
    repeat (2) ne;
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
